mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. It consumes the M-stage control and data signals that the execute-to-memory register produces.
- It runs loads and stores against the data memory through a request/grant/rvalid handshake, and aligns and extends load data.
- It holds the memory-to-writeback pipeline register. StallM is asserted while a memory access is outstanding.

Parameters:
- word_width, 32, datapath width. Only 32 is supported.
- addr_lsb, 2, number of byte-offset bits dropped from dmem_addr. Fixed by word_width/8.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous reset, active-high
- ValidM  in  1  M-stage slot holds a real instruction (0 = bubble)
- RegWriteM  in  1  register write enable
- ResultSrcM  in  2  result select; 2'b01 = load
- MemWriteM  in  1  store
- Funct3M  in  3  access size/sign
- ALUResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4
- StallM  out  1  freeze PC/F/D/E/M registers this cycle (combinational)
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {ALUResultM[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- ValidW, RegWriteW  out  1 each  W-stage valid and register write enable
- ResultSrcW  out  2  W-stage result select
- ALUResultW, ReadDataW, PCPlus4W  out  32 each  W-stage ALU result, extended load data, PC+4
- RdW  out  5  W-stage destination register
- MisalignW  out  1  W-stage instruction was a misaligned or unsupported access; its write is suppressed

Behaviour:
- memop = ValidM & (MemWriteM | ResultSrcM==2'b01). load = memop & !MemWriteM.
- bad access (no request issued):
  - halfword (Funct3M[1:0]=01) with addr[0]=1
  - word (Funct3M=010) with addr[1:0]!=0
  - Funct3M in {011,110,111}
  - store with Funct3M[2]=1
- FSM states IDLE, REQ, WAIT. Reset puts the FSM in IDLE.
- IDLE:
  - memop & !bad: dmem_req=1.
  - gnt & store: access complete, no stall, stay IDLE.
  - gnt & load: StallM=1, go to WAIT.
  - !gnt: StallM=1, go to REQ.
- REQ:
  - dmem_req=1, StallM=1.
  - gnt: store goes to IDLE (completes this cycle); load goes to WAIT.
  - StallM deasserts in the cycle the store's gnt arrives.
- WAIT:
  - dmem_req=0.
  - StallM=1 until the dmem_rvalid cycle. In that cycle StallM=0, data is captured into W, and the FSM goes to IDLE.
- dmem_rvalid in IDLE or REQ is ignored, including stale responses after reset.
- M inputs are held stable by StallM. dmem_addr, dmem_we, dmem_be and dmem_wdata are combinational from the M inputs.
- Store lanes (o = addr[1:0]):
  - SB: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<o.
  - SH: wdata={2{WriteDataM[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata=WriteDataM, be=1111.
- Load extract from dmem_rdata:
  - byte at bits [8o+7:8o]; LB sign-extends, LBU zero-extends.
  - halfword at addr[1] ? [31:16] : [15:0]; LH sign-extends, LHU zero-extends.
  - LW returns the whole word.
- For non-memory instructions, StallM=0 and dmem_req=0.
- W register on each rising edge:
  - reset: all W outputs 0.
  - StallM=1: insert bubble (ValidW=0, RegWriteW=0, MisalignW=0); other W fields don't care, held.
  - otherwise: copy M fields.
    - ReadDataW = extended load data for a completing load, else 0.
    - bad access: MisalignW=1, RegWriteW=0.
- Load-use latency: with gnt in IDLE and rvalid one cycle later, a load occupies M for 2 cycles.
- Reset mid-access: FSM goes to IDLE, dmem_req=0 in the reset cycle. A later rvalid is ignored.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, gnt same cycle -> dmem_req=1, we=1, addr=0x104, be=1111, StallM=0; next cycle ValidW=1, RegWriteW=0.
- SB addr 0x203, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
- LB addr 0x102, gnt immediately, rvalid next cycle with rdata 0x12F03456 -> StallM high 1 cycle; ReadDataW=0xFFFFFFF0, RegWriteW=1, RdW preserved. Same access as LBU -> ReadDataW=0x000000F0.
- LH addr 0x102 with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> StallM=1 for 5 cycles, W receives 5 bubbles, then ReadDataW=0x000012F0 sign-extended as 0x000012F0.
- LW addr 0x101 -> no dmem_req, StallM=0; next cycle MisalignW=1, RegWriteW=0, ValidW=1.
- Reset asserted while in WAIT, then rvalid pulses -> dmem_req=0, all W outputs 0, no capture; the next load completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I memory stage: dmem handshake, load align/extend, M/W register
module mem_access_stage #(
  parameter int word_width = 32,
  parameter int addr_lsb   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        ValidW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        MisalignW
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state;

  logic       memop, store, bad, go;
  logic [1:0] off;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  assign off   = ALUResultM[1:0];
  assign memop = ValidM & (MemWriteM | (ResultSrcM == 2'b01));
  assign store = MemWriteM;

  // Misaligned or unsupported encodings never reach the memory.
  assign bad = memop & (((Funct3M[1:0] == 2'b01) & off[0]) |
                        ((Funct3M == 3'b010) & (off != 2'b00)) |
                        (Funct3M == 3'b011) | (Funct3M == 3'b110) | (Funct3M == 3'b111) |
                        (MemWriteM & Funct3M[2]));
  assign go = memop & ~bad;

  assign dmem_addr = {ALUResultM[word_width-1:addr_lsb], {addr_lsb{1'b0}}};
  assign dmem_we   = store;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        dmem_be    = off[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    StallM   = 1'b0;
    case (state)
      S_IDLE: begin
        dmem_req = go;
        StallM   = go & ~(dmem_gnt & store);
      end
      S_REQ: begin
        dmem_req = 1'b1;
        StallM   = ~(dmem_gnt & store);
      end
      S_WAIT: StallM = ~dmem_rvalid;
      default: ;
    endcase
    if (reset) dmem_req = 1'b0;
  end

  always_comb begin
    case (off)
      2'b00:   rbyte = dmem_rdata[7:0];
      2'b01:   rbyte = dmem_rdata[15:8];
      2'b10:   rbyte = dmem_rdata[23:16];
      default: rbyte = dmem_rdata[31:24];
    endcase
    rhalf = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (Funct3M)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_data = {24'h0, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_data = {16'h0, rhalf};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (go) state <= dmem_gnt ? (store ? S_IDLE : S_WAIT) : S_REQ;
        S_REQ:  if (dmem_gnt) state <= store ? S_IDLE : S_WAIT;
        S_WAIT: if (dmem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      PCPlus4W   <= 32'h0;
      RdW        <= 5'h0;
      MisalignW  <= 1'b0;
    end else if (StallM) begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
    end else begin
      ValidW     <= ValidM;
      RegWriteW  <= RegWriteM & ~bad;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (state == S_WAIT && dmem_rvalid) ? load_data : 32'h0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      MisalignW  <= bad;
    end
  end

endmodule
